// File: rtl/pc_upstream_serializer_if.sv
// Valid/ack channel bundle for the upstream serializer:
// wide word in, {code, chunk} PC words out.
interface pc_upstream_serializer_if #(
    parameter int Nin    = 43,
    parameter int Nchunk = 16,
    parameter int Ncode  = 8
);
    localparam int Nout = Ncode + Nchunk;

    logic [Nin-1:0]   in_d;
    logic [Ncode-1:0] in_code;
    logic             in_v;
    logic             in_a;
    logic [Nout-1:0]  out_d;
    logic             out_v;
    logic             out_a;
    logic             busy;

    modport slave (
        input  in_d, in_code, in_v, out_a,
        output in_a, out_d, out_v, busy
    );

    modport master (
        output in_d, in_code, in_v, out_a,
        input  in_a, out_d, out_v, busy
    );
endinterface

// File: rtl/pc_upstream_serializer.sv
// Splits one wide word into Nchunk-bit PC words tagged with a route
// code, least-significant chunk first, with zero-bubble word chaining.
module pc_upstream_serializer #(
    parameter int Nin    = 43,
    parameter int Nchunk = 16,
    parameter int Ncode  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    pc_upstream_serializer_if.slave  bus
);
    localparam int Nchunks = (Nin + Nchunk - 1) / Nchunk;
    localparam int Nw      = Nchunks * Nchunk;
    localparam int IW      = (Nchunks > 1) ? $clog2(Nchunks) : 1;
    localparam logic [IW-1:0] LAST = IW'(Nchunks - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [Nw-1:0]    r_data;
    logic [Ncode-1:0] r_code;

    logic              w_last;
    logic              w_send;
    logic              w_take;
    logic [Nchunk-1:0] w_chunk;

    assign w_send = (r_state == S_SEND);
    assign w_last = (r_idx == LAST);

    // Final-chunk ack frees the holding registers in the same edge.
    assign bus.in_a  = !w_send || (w_last && bus.out_a);
    assign w_take    = bus.in_v && bus.in_a;
    assign bus.out_v = w_send;
    assign bus.busy  = w_send;

    always_comb begin
        w_chunk = '0;
        for (int i = 0; i < Nchunks; i++) begin
            if (r_idx == IW'(i)) begin
                w_chunk = r_data[i*Nchunk +: Nchunk];
            end
        end
    end

    assign bus.out_d = w_send ? {r_code, w_chunk} : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_code  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_data  <= Nw'(bus.in_d);
                        r_code  <= bus.in_code;
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.out_a) begin
                        if (!w_last) begin
                            r_idx <= r_idx + IW'(1);
                        end else if (w_take) begin
                            r_data <= Nw'(bus.in_d);
                            r_code <= bus.in_code;
                            r_idx  <= '0;
                        end else begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pc_upstream_serializer.md
Name: pc_upstream_serializer

Overview:
- Upstream counterpart of the PC-side configuration deserializer.
- Accepts one wide FPGA-internal word plus a route code on a valid/ack channel.
- Splits the word into Nchunk-bit payload chunks and emits each as one PC word {code, chunk}, least-significant chunk first.
- Sits between internal report sources (tag/readback streams) and the PC output path.

Parameters:
- Nin, 43, width of the incoming data word
- Nchunk, 16, payload bits per emitted PC word
- Ncode, 8, route code width prepended to every chunk
- Nout, Ncode+Nchunk (24), emitted PC word width
- Nchunks (localparam), ceil(Nin/Nchunk) (3), chunks per input word; must be >= 1

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- in_d  input  Nin  wide word to serialize
- in_code  input  Ncode  route code for the word
- in_v  input  1  input valid
- in_a  output  1  input ack; transfer when in_v & in_a at a rising edge
- out_d  output  Nout  {code, chunk}
- out_v  output  1  output valid
- out_a  input  1  downstream ack; transfer when out_v & out_a at a rising edge
- busy  output  1  high while a captured word has chunks not yet transferred

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, chunk index=0, data/code holding registers=0.
  - out_v=0, out_d=0, busy=0, in_a=1 from the following cycle.
  - Reset mid-word discards remaining chunks; no partial word resumes.
- States:
  - IDLE:
    - in_a=1, out_v=0.
    - On in_v & in_a: latch in_d zero-extended to Nchunks*Nchunk bits, latch in_code, index=0, go to SEND.
  - SEND:
    - out_v=1, out_d={code_reg, data_reg[index*Nchunk +: Nchunk]}.
    - Padding bits above Nin are 0.
    - On out_a with index<Nchunks-1: index+=1, stay in SEND.
    - On out_a with index==Nchunks-1: the word is done.
      - If in_v is also high, capture the next word in the same edge, index=0, stay in SEND.
      - Otherwise go to IDLE.
- in_a = (state==IDLE) | (state==SEND & index==Nchunks-1 & out_a). This is a combinational out_a->in_a path and is permitted.
- Latency: first chunk is valid the cycle after the input handshake. With out_a held high, one chunk per cycle and zero bubbles between consecutive words (Nchunks cycles per word).
- Backpressure: while out_v & !out_a, out_d and out_v hold stable and in_a=0.
- busy = (state==SEND).
- Code field is identical for all chunks of a word. Chunk order is strictly ascending.
- Nchunks==1: every accepted word produces exactly one output word, and throughput is 1 word per cycle.
- in_d and in_code are sampled only on the input handshake. Later changes do not affect a word in flight.

Test Plan:
- Basic word: Nin=43, in_d=43'h3_1234_5678, in_code=8'h2A, out_a=1.
  - Required output: 24'h2A5678, 24'h2A1234, 24'h2A0003 on 3 consecutive cycles starting 1 cycle after the in handshake.
  - in_a=0 during the first two chunks. busy falls after the third chunk.
- Backpressure: same word, out_a=0 for 3 cycles while chunk 24'h2A1234 is presented.
  - out_d stays 24'h2A1234 and out_v=1 throughout; no chunk is skipped or duplicated.
- Back-to-back: word A (code 8'h01, data 43'h0_0000_0001) and word B (code 8'h02, data 43'h7_FFFF_FFFF), in_v and out_a held high.
  - Required output on 6 consecutive cycles: 010001, 010000, 010000, 02FFFF, 02FFFF, 020007.
  - No idle cycle between words.
- Reset mid-operation: assert reset=0 for 1 cycle after the first chunk transfers.
  - Next cycle: out_v=0, busy=0, in_a=1.
  - A new word then serializes fully from chunk 0.
- Exact fit: Nin=32, Nchunk=16, in_d=32'hDEAD_BEEF, code 8'h10.
  - Required output: 24'h10BEEF then 24'h10DEAD, 2 chunks, no padding word.
- Input ignored when busy: change in_d during SEND while in_v=1 with no final-chunk ack.
  - The emitted chunks reflect only the originally captured word, and in_a stays 0 until the last chunk is acked.
